// File: rtl/comma_align_ctrl.sv
// Receive word-alignment controller: steps the barrel-shifter offset until K28.5
// commas appear reliably, holds lock, and gates rx_valid on clean locked words.
module comma_align_ctrl #(
    parameter int COMMA_NUMBER = 4,
    parameter int HUNT_WORDS   = 16,
    parameter int SETTLE       = 2,
    parameter int LOSS_LIMIT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] aligned_word,
    input  logic       code_err,
    output logic [3:0] slip_offset,
    output logic       slip,
    output logic       lock,
    output logic       comma_det,
    output logic       lock_lost,
    output logic       rx_valid,
    output logic [9:0] data_out,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] LP_CN     = 4'(COMMA_NUMBER);
    localparam logic [5:0] LP_HW     = 6'(HUNT_WORDS);
    localparam logic [2:0] LP_SETTLE = 3'(SETTLE);
    localparam logic [3:0] LP_LL     = 4'(LOSS_LIMIT);

    state_t     r_state;
    logic [3:0] r_offset;
    logic       r_slip;
    logic       r_lock;
    logic       r_comma_det;
    logic       r_lock_lost;
    logic       r_rx_valid;
    logic [9:0] r_data;
    logic [5:0] r_hunt_cnt;
    logic [5:0] r_gap_cnt;
    logic [3:0] r_good_cnt;
    logic [3:0] r_err_cnt;
    logic [2:0] r_settle;

    logic       w_comma;
    logic [3:0] w_next_off;
    logic [5:0] w_hunt_inc;
    logic [5:0] w_gap_inc;
    logic [3:0] w_good_inc;
    logic [3:0] w_err_inc;

    assign w_comma    = (aligned_word == 10'h0FA) || (aligned_word == 10'h305);
    assign w_next_off = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
    assign w_hunt_inc = r_hunt_cnt + 6'd1;
    assign w_gap_inc  = r_gap_cnt + 6'd1;
    assign w_good_inc = r_good_cnt + 4'd1;
    assign w_err_inc  = r_err_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_offset    <= 4'd0;
            r_slip      <= 1'b0;
            r_lock      <= 1'b0;
            r_comma_det <= 1'b0;
            r_lock_lost <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_data      <= 10'd0;
            r_hunt_cnt  <= 6'd0;
            r_gap_cnt   <= 6'd0;
            r_good_cnt  <= 4'd0;
            r_err_cnt   <= 4'd0;
            r_settle    <= LP_SETTLE;
        end else begin
            r_data      <= aligned_word;
            r_rx_valid  <= (r_state == ST_LOCKED) && !code_err;
            r_slip      <= 1'b0;
            r_comma_det <= 1'b0;
            r_lock_lost <= 1'b0;
            if (!enable) begin
                r_state     <= ST_HUNT;
                r_lock      <= 1'b0;
                r_lock_lost <= (r_state == ST_LOCKED);
                r_hunt_cnt  <= 6'd0;
                r_gap_cnt   <= 6'd0;
                r_good_cnt  <= 4'd0;
                r_err_cnt   <= 4'd0;
                r_settle    <= LP_SETTLE;
            end else if (r_settle != 3'd0) begin
                // shifter output still reflects the previous offset
                r_settle <= r_settle - 3'd1;
            end else begin
                unique case (r_state)
                    ST_HUNT: begin
                        if (w_comma) begin
                            r_comma_det <= 1'b1;
                            r_good_cnt  <= 4'd1;
                            r_gap_cnt   <= 6'd0;
                            r_hunt_cnt  <= 6'd0;
                            if (LP_CN == 4'd1) begin
                                r_state   <= ST_LOCKED;
                                r_lock    <= 1'b1;
                                r_err_cnt <= 4'd0;
                            end else begin
                                r_state <= ST_VERIFY;
                            end
                        end else if (w_hunt_inc == LP_HW) begin
                            r_offset   <= w_next_off;
                            r_slip     <= 1'b1;
                            r_hunt_cnt <= 6'd0;
                            r_settle   <= LP_SETTLE;
                        end else begin
                            r_hunt_cnt <= w_hunt_inc;
                        end
                    end
                    ST_VERIFY: begin
                        if (code_err || (!w_comma && (w_gap_inc == LP_HW))) begin
                            r_offset   <= w_next_off;
                            r_slip     <= 1'b1;
                            r_state    <= ST_HUNT;
                            r_hunt_cnt <= 6'd0;
                            r_gap_cnt  <= 6'd0;
                            r_good_cnt <= 4'd0;
                            r_settle   <= LP_SETTLE;
                        end else if (w_comma) begin
                            r_comma_det <= 1'b1;
                            r_gap_cnt   <= 6'd0;
                            r_good_cnt  <= w_good_inc;
                            if (w_good_inc == LP_CN) begin
                                r_state   <= ST_LOCKED;
                                r_lock    <= 1'b1;
                                r_err_cnt <= 4'd0;
                            end
                        end else begin
                            r_gap_cnt <= w_gap_inc;
                        end
                    end
                    ST_LOCKED: begin
                        r_comma_det <= w_comma;
                        // loss of lock re-hunts at the same offset before slipping
                        if (!code_err) begin
                            r_err_cnt <= 4'd0;
                        end else if (w_err_inc == LP_LL) begin
                            r_state     <= ST_HUNT;
                            r_lock      <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_err_cnt   <= 4'd0;
                            r_hunt_cnt  <= 6'd0;
                            r_gap_cnt   <= 6'd0;
                            r_good_cnt  <= 4'd0;
                            r_settle    <= LP_SETTLE;
                        end else begin
                            r_err_cnt <= w_err_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign slip_offset = r_offset;
    assign slip        = r_slip;
    assign lock        = r_lock;
    assign comma_det   = r_comma_det;
    assign lock_lost   = r_lock_lost;
    assign rx_valid    = r_rx_valid;
    assign data_out    = r_data;
    assign state       = r_state;

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Scoreboard bench for comma_align_ctrl: directed words push hand-derived expected
// outputs; a monitor pops one entry per clock and compares.
module tb_comma_align_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] aligned_word;
    logic       code_err;
    logic [3:0] slip_offset;
    logic       slip;
    logic       lock;
    logic       comma_det;
    logic       lock_lost;
    logic       rx_valid;
    logic [9:0] data_out;
    logic [1:0] state;

    always #5 clk = ~clk;

    comma_align_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .aligned_word (aligned_word),
        .code_err     (code_err),
        .slip_offset  (slip_offset),
        .slip         (slip),
        .lock         (lock),
        .comma_det    (comma_det),
        .lock_lost    (lock_lost),
        .rx_valid     (rx_valid),
        .data_out     (data_out),
        .state        (state)
    );

    localparam logic [1:0] HUNT   = 2'b00;
    localparam logic [1:0] VERIFY = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;

    typedef struct {
        logic [1:0] st;
        logic       lk;
        logic       sl;
        logic [3:0] off;
        logic       cd;
        logic       ll;
        logic       rv;
        logic [9:0] data;
        string      tag;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fill_n  = 0;
    logic [3:0] e_off   = 4'd0;
    string      phase   = "reset";

    // Non-comma filler; includes K28.1-like 0x0F9, which must not count as a comma
    function automatic logic [9:0] fw();
        fill_n++;
        if (fill_n % 7 == 0) return 10'h0F9;
        return {2'b10, 8'(fill_n)};
    endfunction

    function automatic logic [9:0] cm(input int k);
        return k[0] ? 10'h305 : 10'h0FA;
    endfunction

    task automatic step(input logic [9:0] w, input logic err, input logic en,
                        input logic [1:0] st, input logic sl, input logic cd,
                        input logic ll, input logic rv);
        exp_t x;
        @(negedge clk);
        rst          = 1'b0;
        aligned_word = w;
        code_err     = err;
        enable       = en;
        x.st = st; x.lk = (st == LOCKED); x.sl = sl; x.off = e_off;
        x.cd = cd; x.ll = ll; x.rv = rv; x.data = w; x.tag = phase;
        q.push_back(x);
    endtask

    task automatic rst_step();
        exp_t x;
        @(negedge clk);
        rst          = 1'b1;
        aligned_word = 10'($urandom);
        code_err     = 1'($urandom);
        enable       = 1'($urandom);
        e_off        = 4'd0;
        x.st = HUNT; x.lk = 1'b0; x.sl = 1'b0; x.off = 4'd0;
        x.cd = 1'b0; x.ll = 1'b0; x.rv = 1'b0; x.data = 10'd0; x.tag = phase;
        q.push_back(x);
    endtask

    task automatic settle2();
        for (int i = 0; i < 2; i++) step(fw(), 1'b0, 1'b1, HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lock4();
        for (int k = 0; k < 4; k++)
            step(cm(k), 1'b0, 1'b1, (k == 3) ? LOCKED : VERIFY, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic hunt_period(input logic [3:0] nxt);
        for (int i = 0; i < 17; i++) step(fw(), 1'b0, 1'b1, HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
        e_off = nxt;
        step(fw(), 1'b0, 1'b1, HUNT, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_tests++;
                if (state !== x.st || lock !== x.lk || slip !== x.sl || slip_offset !== x.off ||
                    comma_det !== x.cd || lock_lost !== x.ll || rx_valid !== x.rv || data_out !== x.data) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got st=%b lock=%b slip=%b off=%0d cdet=%b llost=%b rxv=%b data=%h; want st=%b lock=%b slip=%b off=%0d cdet=%b llost=%b rxv=%b data=%h",
                             x.tag, $time, state, lock, slip, slip_offset, comma_det, lock_lost, rx_valid, data_out,
                             x.st, x.lk, x.sl, x.off, x.cd, x.ll, x.rv, x.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; code_err = 1'b0; aligned_word = 10'd0;

        phase = "reset";
        repeat (3) rst_step();

        phase = "settle_ignore";
        step(10'h0FA, 1'b0, 1'b1, HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
        step(10'h305, 1'b0, 1'b1, HUNT, 1'b0, 1'b0, 1'b0, 1'b0);

        phase = "fast_lock";
        step(10'h305, 1'b0, 1'b1, VERIFY, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) step(fw(), 1'b0, 1'b1, VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
            step(cm(k), 1'b0, 1'b1, (k == 2) ? LOCKED : VERIFY, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        phase = "locked_data";
        for (int i = 0; i < 3; i++) step(fw(), 1'b0, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b1);
        step(10'h0FA, 1'b0, 1'b1, LOCKED, 1'b0, 1'b1, 1'b0, 1'b1);
        step(fw(), 1'b0, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "err3_hold";
        for (int i = 0; i < 3; i++) step(fw(), 1'b1, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b0);
        step(fw(), 1'b0, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "err4_loss";
        step(fw(), 1'b1, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b0);
        step(10'h0FA, 1'b1, 1'b1, LOCKED, 1'b0, 1'b1, 1'b0, 1'b0);
        step(fw(), 1'b1, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b0);
        step(fw(), 1'b1, 1'b1, HUNT, 1'b0, 1'b0, 1'b1, 1'b0);

        phase = "relock_same_off";
        settle2();
        lock4();
        step(fw(), 1'b0, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "enable_drop";
        step(fw(), 1'b1, 1'b0, HUNT, 1'b0, 1'b0, 1'b1, 1'b0);
        step(10'h0FA, 1'b0, 1'b0, HUNT, 1'b0, 1'b0, 1'b0, 1'b0);
        step(fw(), 1'b0, 1'b0, HUNT, 1'b0, 1'b0, 1'b0, 1'b0);

        phase = "reenable_relock";
        settle2();
        lock4();
        step(fw(), 1'b0, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "reset_mid_lock";
        rst_step();

        phase = "search_off3";
        hunt_period(4'd1);
        hunt_period(4'd2);
        hunt_period(4'd3);
        settle2();
        lock4();
        step(fw(), 1'b0, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b1);

        phase = "loss_off3";
        for (int i = 0; i < 3; i++) step(fw(), 1'b1, 1'b1, LOCKED, 1'b0, 1'b0, 1'b0, 1'b0);
        step(fw(), 1'b1, 1'b1, HUNT, 1'b0, 1'b0, 1'b1, 1'b0);

        phase = "verify_gap";
        settle2();
        step(cm(0), 1'b0, 1'b1, VERIFY, 1'b0, 1'b1, 1'b0, 1'b0);
        step(cm(1), 1'b0, 1'b1, VERIFY, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(fw(), 1'b0, 1'b1, VERIFY, 1'b0, 1'b0, 1'b0, 1'b0);
        e_off = 4'd4;
        step(fw(), 1'b0, 1'b1, HUNT, 1'b1, 1'b0, 1'b0, 1'b0);

        phase = "verify_err_comma";
        settle2();
        step(cm(0), 1'b0, 1'b1, VERIFY, 1'b0, 1'b1, 1'b0, 1'b0);
        e_off = 4'd5;
        step(cm(1), 1'b1, 1'b1, HUNT, 1'b1, 1'b0, 1'b0, 1'b0);

        phase = "sweep_wrap";
        hunt_period(4'd6);
        hunt_period(4'd7);
        hunt_period(4'd8);
        hunt_period(4'd9);
        hunt_period(4'd0);

        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
